// File: rtl/delay_ram_responder.sv
// Synchronous-write / combinational-read SRAM stand-in for the delay-line bus.
// Optional DELAY_RAM_STATS_EN adds saturating write/read access counters.
`ifndef DelayAddrWidth
`define DelayAddrWidth 4
`endif
`ifndef DelayDataWidth
`define DelayDataWidth 16
`endif
`ifndef DelayDepth
`define DelayDepth 16
`endif

module delay_ram_responder #(
  parameter int ADDR_WIDTH = `DelayAddrWidth,
  parameter int DATA_WIDTH = `DelayDataWidth,
  parameter int DEPTH      = `DelayDepth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  WE,
  input  logic                  OE,
  output logic                  ready,
  output logic                  bus_error,
`ifdef DELAY_RAM_STATS_EN
  output logic [15:0]           write_count,
  output logic [15:0]           read_count,
`endif
  output logic                  oob_error
);

  typedef enum logic {CLEAR, SERVE} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  drive;
  logic [DATA_WIDTH-1:0] rd_data;

  assign in_range = {1'b0, address} < DEPTH_W;
  assign wr_ok    = ready & WE & ~OE & in_range;
  assign rd_ok    = ready & OE & ~WE & in_range;

  // Out-of-range reads still drive the bus, with zero.
  assign drive   = ready & OE & ~WE & ~reset;
  assign rd_data = in_range ? mem[address] : '0;
  assign data    = drive ? rd_data : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      ready     <= 1'b0;
      bus_error <= 1'b0;
      oob_error <= 1'b0;
      ptr       <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          mem[ptr] <= '0;
          ptr      <= ptr + 1'b1;
          if (ptr == LAST) begin
            state <= SERVE;
            ready <= 1'b1;
          end
        end
        SERVE: begin
          if (wr_ok)
            mem[address] <= data;
          if (WE & OE)
            bus_error <= 1'b1;
          if ((WE | OE) & ~in_range)
            oob_error <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

`ifdef DELAY_RAM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      write_count <= '0;
      read_count  <= '0;
    end else begin
      if (wr_ok && write_count != 16'hFFFF)
        write_count <= write_count + 16'd1;
      if (rd_ok && read_count != 16'hFFFF)
        read_count <= read_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_delay_ram_responder.sv
// Directed bench for delay_ram_responder: DEPTH=16 main instance plus a
// DEPTH=12 instance for out-of-range accesses.
module tb_delay_ram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, we, oe, tb_en;
  logic [3:0]  addr;
  logic [15:0] tb_drv;
  wire  [15:0] data;
  logic        ready, bus_error, oob_error;

  logic        r12, we12, oe12, en12;
  logic [3:0]  a12;
  logic [15:0] drv12;
  wire  [15:0] data12;
  logic        ready12, be12, oob12;

`ifdef DELAY_RAM_STATS_EN
  logic [15:0] wcnt, rcnt, wcnt12, rcnt12;
`endif

  assign data   = tb_en ? tb_drv : 16'hzzzz;
  assign data12 = en12 ? drv12 : 16'hzzzz;

  delay_ram_responder #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset), .address(addr), .data(data),
    .WE(we), .OE(oe), .ready(ready), .bus_error(bus_error),
`ifdef DELAY_RAM_STATS_EN
    .write_count(wcnt), .read_count(rcnt),
`endif
    .oob_error(oob_error)
  );

  delay_ram_responder #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(12)
  ) dut12 (
    .clk(clk), .reset(r12), .address(a12), .data(data12),
    .WE(we12), .OE(oe12), .ready(ready12), .bus_error(be12),
`ifdef DELAY_RAM_STATS_EN
    .write_count(wcnt12), .read_count(rcnt12),
`endif
    .oob_error(oob12)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] KEEP = 16'h0F0F;

  typedef struct {
    logic        w;
    logic        o;
    logic [3:0]  a;
    logic        en;
    logic [15:0] v;
    logic [15:0] exp_d;
    logic        exp_be;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic set(input logic w, input logic o, input logic [3:0] a,
                     input logic en, input logic [15:0] v);
    we = w; oe = o; addr = a; tb_en = en; tb_drv = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    chk(nm, n, 16);
  endtask

  initial begin
    int n;
    vt[0]  = '{1, 0, 4'd3,  1, 16'hBEEF, 16'hBEEF, 0};
    vt[1]  = '{0, 1, 4'd3,  0, 16'h0000, 16'hBEEF, 0};
    vt[2]  = '{0, 0, 4'd3,  1, KEEP,     KEEP,     0};
    vt[3]  = '{1, 0, 4'd15, 1, 16'h1234, 16'h1234, 0};
    vt[4]  = '{1, 0, 4'd0,  1, 16'h5678, 16'h5678, 0};
    vt[5]  = '{0, 1, 4'd15, 0, 16'h0000, 16'h1234, 0};
    vt[6]  = '{0, 1, 4'd0,  0, 16'h0000, 16'h5678, 0};
    vt[7]  = '{1, 0, 4'd5,  1, 16'h5555, 16'h5555, 0};
    vt[8]  = '{1, 1, 4'd5,  1, 16'hAAAA, 16'hAAAA, 0};
    vt[9]  = '{0, 1, 4'd5,  0, 16'h0000, 16'h5555, 1};
    vt[10] = '{0, 1, 4'd3,  0, 16'h0000, 16'hBEEF, 1};

    reset = 1'b1;
    set(0, 0, 4'd0, 1, KEEP);
    r12 = 1'b1; we12 = 0; oe12 = 0; a12 = 0; en12 = 1; drv12 = KEEP;
    tick();
    @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_oob_error", oob_error, 0);
    chk("rst_bus_released", data, KEEP);
    tick();
    reset = 1'b0;

    // Test 1: sweep length and cleared contents
    wait_ready("sweep_len");
    for (int i = 0; i < 16; i++) begin
      set(0, 1, 4'(i), 0, 16'h0);
      @(negedge clk);
      chk($sformatf("clear_rd_%0d", i), data, 16'h0000);
      tick();
    end

    // Tests 2-4: table vectors
    for (int i = 0; i < 11; i++) begin
      set(vt[i].w, vt[i].o, vt[i].a, vt[i].en, vt[i].v);
      @(negedge clk);
      chk($sformatf("vec%0d_data", i), data, vt[i].exp_d);
      chk($sformatf("vec%0d_bus_err", i), bus_error, vt[i].exp_be);
      tick();
    end
    chk("oob_after_vecs", oob_error, 0);

    // Test 5: DEPTH=12 out-of-range accesses
    r12 = 1'b0;
    n = 0;
    while (!ready12 && n < 40) begin
      tick();
      n++;
    end
    chk("d12_sweep_len", n, 12);
    we12 = 1; oe12 = 0; a12 = 4'd13; en12 = 1; drv12 = 16'h1111;
    tick();
    chk("d12_oob_set", oob12, 1);
    chk("d12_no_bus_err", be12, 0);
    we12 = 0; oe12 = 1; en12 = 0;
    @(negedge clk);
    chk("d12_oob_rd", data12, 16'h0000);
    tick();
    we12 = 1; oe12 = 1; en12 = 1; drv12 = 16'h2222;
    tick();
    chk("d12_both_be", be12, 1);
    chk("d12_both_oob", oob12, 1);
    we12 = 0; oe12 = 0; r12 = 1'b1;
    tick();
    chk("d12_rst_oob", oob12, 0);
    chk("d12_rst_be", be12, 0);
    r12 = 1'b0;

    // Test 6: reset during a read releases bus immediately
    set(0, 1, 4'd3, 1, KEEP);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_same_cycle_release", data, KEEP);
    tick();
    chk("rst_clears_be", bus_error, 0);
    set(0, 0, 4'd0, 1, KEEP);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready("resweep_len");

    for (int i = 1; i <= 3; i++) begin
      set(1, 0, 4'(i), 1, 16'(i * 16'h0101));
      tick();
    end
    set(0, 1, 4'd3, 0, 16'h0);
    @(negedge clk);
    chk("post_rst_rd3", data, 16'h0303);
    tick();
    set(0, 1, 4'd5, 0, 16'h0);
    @(negedge clk);
    chk("post_rst_rd5_cleared", data, 16'h0000);
    tick();
    set(0, 0, 4'd0, 1, KEEP);
`ifdef DELAY_RAM_STATS_EN
    chk("write_count", wcnt, 16'd3);
    chk("read_count", rcnt, 16'd2);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
